fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage upstream of the multi-cycle control FSM. It owns the program counter and the instruction register. It fetches one 16-bit word per PC value from instruction memory over a req/ack handshake and presents the instruction to the controller. It consumes the controller's pc_en, pc_inc_or_set and ir_en strobes.

Parameters:
ADDR_WIDTH, 16, width of PC and instruction memory address
RESET_PC, 0, PC value loaded on reset

Ports:
clock  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-low; clock clock
pc_en  input  1  one-cycle strobe: update PC this cycle
pc_inc_or_set  input  1  0 = PC+1, 1 = load target_addr (sampled only with pc_en)
target_addr  input  ADDR_WIDTH  branch/jump target
ir_en  input  1  one-cycle strobe: move fetched word into instruction register
mem_req  output  1  read request to instruction memory
mem_addr  output  ADDR_WIDTH  read address, stable while mem_req=1
mem_rdata  input  16  read data, valid when mem_ack=1
mem_ack  input  1  read complete; may assert in the same cycle mem_req first rises
instruction  output  16  instruction register contents
pc  output  ADDR_WIDTH  current program counter
fetch_valid  output  1  prefetch buffer holds the word for the current pc
ir_underrun  output  1  one-cycle pulse: ir_en arrived while fetch_valid=0

Behaviour:
- Reset (reset=0 at a rising edge): pc=RESET_PC, instruction=16'h0000, buffer=0, fetch_valid=0, mem_req=0, mem_addr=RESET_PC, ir_underrun=0, state=F_REQ. All other inputs are ignored while reset is low.
- States: F_REQ (request outstanding), F_FULL (word buffered), F_IDLE (buffer consumed, waiting for PC update), F_FLUSH (request outstanding for a stale PC).
- F_REQ: mem_req=1, mem_addr=latched fetch address (captured from pc on entry).
  - mem_ack without pc_en: buffer<=mem_rdata, fetch_valid<=1, go to F_FULL.
  - pc_en without ack: go to F_FLUSH.
  - mem_ack and pc_en together: discard data, go to F_REQ with the new pc.
- F_FLUSH: mem_req stays 1 and mem_addr is unchanged (handshake is never abandoned).
  - On mem_ack, discard data and go to F_REQ with the current pc.
  - Further pc_en strobes update pc only.
- F_FULL: fetch_valid=1, mem_req=0.
  - ir_en: instruction<=buffer, fetch_valid<=0, go to F_IDLE.
  - pc_en alone: fetch_valid<=0, go to F_REQ (buffer is stale).
  - ir_en and pc_en together: instruction captured first, then go to F_REQ.
- F_IDLE: mem_req=0. pc_en moves the block to F_REQ.
- PC update on pc_en, in any state except reset: pc<=pc+1 (modulo 2^ADDR_WIDTH, so all-ones wraps to 0) or pc<=target_addr. The new pc is visible the next cycle.
- mem_req is registered. It rises the cycle after entry into F_REQ (from reset or from pc_en) and falls the cycle after the accepting mem_ack.
- mem_ack while mem_req=0 is ignored.
- ir_en when fetch_valid=0 (F_REQ, F_FLUSH, F_IDLE): instruction is unchanged and ir_underrun=1 for one cycle.
- Minimum latency from pc_en to fetch_valid is 2 cycles, with zero-wait memory acking in the first mem_req cycle:
  - cycle n: pc_en
  - cycle n+1: mem_req=1, mem_ack=1
  - cycle n+2: fetch_valid=1
- instruction changes only on ir_en with fetch_valid=1, or on reset.
- Reset asserted mid-request drops mem_req the following cycle. After reset, the block refetches from RESET_PC and any late ack is ignored until mem_req is high again.

Test Plan:
- Reset then zero-wait memory returning mem[0]=16'h5123: mem_req high 1 cycle with mem_addr=0, fetch_valid=1; then ir_en -> instruction=16'h5123, state F_IDLE.
- 3-cycle memory latency: mem_addr held stable for all 3 cycles with mem_req=1, buffer captured only on ack.
- pc_en with pc_inc_or_set=1, target_addr=16'h00A0, issued in F_FULL at pc=5: pc=16'h00A0, fetch_valid drops, next request at addr 16'h00A0.
- pc_en during an outstanding 4-cycle request to addr 2: mem_req held, mem_addr stays 2, data discarded on ack, new request to addr 3, fetch_valid only after the second ack.
- ir_en in F_IDLE: ir_underrun pulses 1 cycle, instruction unchanged; and pc=16'hFFFF with increment -> pc=16'h0000.
- Reset low during F_FLUSH with ack arriving 2 cycles after reset release: mem_req low the cycle after reset, pc=RESET_PC, and the stale ack does not set fetch_valid.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, prefetches one word per PC over a
// req/ack memory handshake and hands it to the controller on ir_en.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pc_en,
  input  logic                  pc_inc_or_set,
  input  logic [ADDR_WIDTH-1:0] target_addr,
  input  logic                  ir_en,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic [15:0]           instruction,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  fetch_valid,
  output logic                  ir_underrun
);

  typedef enum logic [1:0] {
    F_REQ   = 2'd0,
    F_FULL  = 2'd1,
    F_IDLE  = 2'd2,
    F_FLUSH = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             buf_q, buf_d;
  logic [15:0]             instr_q, instr_d;
  logic                    req_q, req_d;
  logic                    under_q, under_d;
  logic                    ack_ok;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= F_REQ;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      buf_q   <= 16'h0000;
      instr_q <= 16'h0000;
      req_q   <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      under_q <= under_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    instr_d = instr_q;
    // An ack only counts against a request we are actually presenting.
    ack_ok  = mem_ack & req_q;
    under_d = ir_en & (state_q != F_FULL);

    if (pc_en)
      pc_d = pc_inc_or_set ? target_addr : pc_q + ADDR_WIDTH'(1);

    unique case (state_q)
      F_REQ: begin
        if (ack_ok && !pc_en) begin
          buf_d   = mem_rdata;
          state_d = F_FULL;
        end else if (pc_en && req_q && !ack_ok) begin
          state_d = F_FLUSH;
        end
      end
      F_FLUSH: begin
        if (ack_ok)
          state_d = F_REQ;
      end
      F_FULL: begin
        if (ir_en)
          instr_d = buf_q;
        if (pc_en)
          state_d = F_REQ;
        else if (ir_en)
          state_d = F_IDLE;
      end
      F_IDLE: begin
        if (pc_en)
          state_d = F_REQ;
      end
      default: state_d = F_REQ;
    endcase

    req_d = (state_d == F_REQ) || (state_d == F_FLUSH);
    // Address is frozen for the life of a handshake; otherwise it follows pc.
    if (!req_q || ack_ok)
      addr_d = pc_d;
  end

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign fetch_valid = (state_q == F_FULL);
  assign ir_underrun = under_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a flag-level fetch model predicts each
// cycle's outputs; a negedge monitor pops and compares against the DUT.
module tb_fetch_unit;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pc_en = 1'b0;
  logic        pc_inc_or_set = 1'b0;
  logic [15:0] target_addr = 16'h0000;
  logic        ir_en = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;
  logic [15:0] instruction;
  logic [15:0] pc;
  logic        fetch_valid;
  logic        ir_underrun;

  fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset), .pc_en(pc_en), .pc_inc_or_set(pc_inc_or_set),
    .target_addr(target_addr), .ir_en(ir_en), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .instruction(instruction), .pc(pc),
    .fetch_valid(fetch_valid), .ir_underrun(ir_underrun)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [15:0] memword(input logic [15:0] a);
    return 16'h5123 ^ {a[7:0], a[15:8]} ^ (a << 3);
  endfunction

  // ---------------- memory responder ----------------
  int lat_mode  = 0;   // <0: random wait 0..3, else fixed wait cycles
  bit spur      = 1'b0;
  bit force_ack = 1'b0;
  bit busy      = 1'b0;
  int wl        = 0;

  always @(negedge clock) begin
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = 16'hDEAD;
      busy      = 1'b0;
    end else if (mem_req === 1'b1) begin
      if (!busy) begin
        busy = 1'b1;
        wl   = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end
      if (wl == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = memword(mem_addr);
        busy      = 1'b0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        wl        = wl - 1;
      end
    end else begin
      busy      = 1'b0;
      mem_ack   = spur && ($urandom_range(0, 3) == 0);
      mem_rdata = 16'($urandom);
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] addr;
    logic        fv;
    logic        req;
    logic        und;
  } exp_t;

  exp_t exp_q[$];

  logic [15:0] m_pc, m_instr, m_addr, m_word;
  bit          m_have, m_req, m_stale, m_want, m_under;

  always @(posedge clock) begin : model
    bit          acc;
    logic [15:0] npc;
    exp_t        e;
    if (!reset) begin
      m_pc = RST_PC; m_instr = 16'h0000; m_addr = RST_PC; m_word = 16'h0000;
      m_have = 0; m_req = 0; m_stale = 0; m_want = 1; m_under = 0;
    end else begin
      acc     = mem_ack && m_req;
      npc     = pc_en ? (pc_inc_or_set ? target_addr : m_pc + 16'd1) : m_pc;
      m_under = ir_en && !m_have;
      if (ir_en && m_have) begin
        m_instr = m_word;
        m_have  = 0;
      end
      if (pc_en) m_have = 0;
      // A returned word is kept only if it still belongs to the live pc.
      if (acc && !m_stale && !pc_en) begin
        m_have = 1;
        m_word = memword(m_addr);
      end
      if (m_req && !acc) begin
        m_stale = m_stale | pc_en;
      end else if (m_want || pc_en || (acc && m_stale)) begin
        m_req = 1; m_addr = npc; m_stale = 0;
      end else begin
        m_req = 0; m_stale = 0;
      end
      m_want = 0;
      m_pc   = npc;
    end
    e.pc = m_pc; e.instr = m_instr; e.addr = m_addr;
    e.fv = m_have; e.req = m_req; e.und = m_under;
    exp_q.push_back(e);
  end

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc",          pc,                   e.pc);
      chk("instruction", instruction,          e.instr);
      chk("fetch_valid", {15'd0, fetch_valid}, {15'd0, e.fv});
      chk("mem_req",     {15'd0, mem_req},     {15'd0, e.req});
      chk("ir_underrun", {15'd0, ir_underrun}, {15'd0, e.und});
      if (e.req) chk("mem_addr", mem_addr, e.addr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit rst, input bit pe, input bit sel,
                      input logic [15:0] tgt, input bit ir, input bit fa);
    @(posedge clock);
    #1;
    reset         = rst;
    pc_en         = pe;
    pc_inc_or_set = sel;
    target_addr   = tgt;
    ir_en         = ir;
    force_ack     = fa;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 16'h0000, 0, 0);
  endtask

  initial begin
    logic [15:0] tgt;
    int          pick;

    // Reset, zero-wait fetch of mem[0], then consume it.
    lat_mode = 0;
    repeat (3) step(0, 0, 0, 16'h0000, 0, 0);
    idle(3);
    step(1, 0, 0, 16'h0000, 1, 0);
    idle(1);

    // Three-cycle memory latency on pc+1.
    lat_mode = 2;
    step(1, 1, 0, 16'h0000, 0, 0);
    idle(6);
    step(1, 0, 0, 16'h0000, 1, 0);

    // Jump issued while a word is buffered at pc=5.
    lat_mode = 0;
    step(1, 1, 1, 16'h0005, 0, 0);
    idle(3);
    step(1, 1, 1, 16'h00A0, 0, 0);
    idle(3);

    // pc_en during an outstanding 4-cycle request to addr 2.
    lat_mode = 3;
    step(1, 1, 1, 16'h0002, 0, 0);
    idle(1);
    step(1, 1, 0, 16'h0000, 0, 0);
    idle(9);

    // Consume, underrun in idle, then wrap from 0xFFFF.
    step(1, 0, 0, 16'h0000, 1, 0);
    step(1, 0, 0, 16'h0000, 1, 0);
    idle(1);
    lat_mode = 0;
    step(1, 1, 1, 16'hFFFF, 0, 0);
    idle(3);
    step(1, 1, 0, 16'h0000, 1, 0);
    idle(3);

    // Reset during a flush; stale acks arrive while no request is up.
    lat_mode = 3;
    step(1, 1, 1, 16'h0010, 0, 0);
    idle(1);
    step(1, 1, 0, 16'h0000, 0, 0);
    step(0, 0, 0, 16'h0000, 0, 1);
    step(0, 0, 0, 16'h0000, 0, 1);
    step(1, 0, 0, 16'h0000, 0, 1);
    lat_mode = 0;
    idle(4);
    step(1, 0, 0, 16'h0000, 1, 0);
    idle(1);

    // Randomized traffic with spurious acks and occasional resets.
    lat_mode = -1;
    spur     = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      pick = int'($urandom_range(0, 3));
      case (pick)
        0:       tgt = 16'hFFFF;
        1:       tgt = 16'hFFFE;
        2:       tgt = 16'($urandom_range(0, 15));
        default: tgt = 16'($urandom);
      endcase
      step($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)), tgt, $urandom_range(0, 2) == 0, 0);
    end

    spur = 1'b0;
    idle(4);
    @(negedge clock);
    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
